// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle between a requester and alu_sequencer.
// master = requester side, slave = sequencer side.
interface alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_con;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_out;
  logic [15:0] rsp_r0;
  logic        rsp_err;

  modport master (
    output req_valid, req_con, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_out, rsp_r0, rsp_err
  );

  modport slave (
    input  req_valid, req_con, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_out, rsp_r0, rsp_err
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU operation, drives a combinational ALU for a
// per-opcode number of cycles, captures the result and holds it until taken.
// Optional macro ALU_SEQ_DIVZERO_TRAP_EN: divide by zero is trapped locally
// (one cycle, rsp_out=FFFF, rsp_r0=dividend, rsp_err=1) instead of issued.
module alu_sequencer #(
  parameter int unsigned MUL_CYC = 2,
  parameter int unsigned DIV_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_sequencer_if.slave bus,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  output logic [3:0]  alu_con,
  input  logic [15:0] alu_out,
  input  logic [15:0] alu_r0,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYC - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYC - 1);

  state_t      state_reg, state_next;
  logic [3:0]  con_reg, cnt_reg, cnt_load;
  logic [15:0] a_reg, b_reg, out_reg, r0_reg;
  logic        err_reg;
  logic        accept, legal_req, legal_cur, trap_req, trap_cur;

  function automatic logic is_legal(input logic [3:0] c);
    case (c)
      4'h1, 4'h2, 4'h4, 4'h8, 4'hC, 4'hE, 4'hF: is_legal = 1'b1;
      default:                                  is_legal = 1'b0;
    endcase
  endfunction

  assign accept    = (state_reg == IDLE) && bus.req_valid;
  assign legal_req = is_legal(bus.req_con);
  assign legal_cur = is_legal(con_reg);

`ifdef ALU_SEQ_DIVZERO_TRAP_EN
  assign trap_req = (bus.req_con == 4'h8) && (bus.req_b == 16'h0000);
  assign trap_cur = (con_reg == 4'h8) && (b_reg == 16'h0000);
`else
  assign trap_req = 1'b0;
  assign trap_cur = 1'b0;
`endif

  // Multi-cycle only for real mul/div; faults and simple ops take one cycle.
  assign cnt_load = (!legal_req || trap_req) ? 4'h0 :
                    (bus.req_con == 4'h4)    ? MUL_LOAD :
                    (bus.req_con == 4'h8)    ? DIV_LOAD : 4'h0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.req_valid) state_next = EXEC;
      EXEC:    if (cnt_reg == 4'h0) state_next = DONE;
      DONE:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, cycle counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      con_reg <= 4'h0;
      cnt_reg <= 4'h0;
      a_reg   <= 16'h0000;
      b_reg   <= 16'h0000;
      out_reg <= 16'h0000;
      r0_reg  <= 16'h0000;
      err_reg <= 1'b0;
    end else begin
      if (accept) begin
        con_reg <= bus.req_con;
        a_reg   <= bus.req_a;
        b_reg   <= bus.req_b;
        cnt_reg <= cnt_load;
      end else if (state_reg == EXEC) begin
        if (cnt_reg != 4'h0) begin
          cnt_reg <= cnt_reg - 4'h1;
        end else if (!legal_cur) begin
          out_reg <= 16'h0000;
          err_reg <= 1'b1;
        end else if (trap_cur) begin
          out_reg <= 16'hFFFF;
          r0_reg  <= a_reg;
          err_reg <= 1'b1;
        end else begin
          out_reg <= alu_out;
          if (con_reg == 4'h4 || con_reg == 4'h8) r0_reg <= alu_r0;
          err_reg <= 1'b0;
        end
      end
    end
  end

  // Outputs decoded from state; ALU opcode only issued for non-faulting EXEC.
  always_comb begin
    bus.req_ready = (state_reg == IDLE) && rst_n;
    bus.rsp_valid = (state_reg == DONE);
    bus.rsp_out   = out_reg;
    bus.rsp_r0    = r0_reg;
    bus.rsp_err   = err_reg;
    busy          = (state_reg != IDLE);
    alu_in1       = a_reg;
    alu_in2       = b_reg;
    alu_con       = 4'h0;
    if (state_reg == EXEC && legal_cur && !trap_cur) alu_con = con_reg;
  end

endmodule
